// File: rtl/rf_multiport_if.sv
// rf_multiport_if: bundle of the register-file bus signals (enable, two write
// ports, two read ports, soft-clear request and busy flag) shared between the
// decode/write-back side (master) and the register file (slave).
interface rf_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RF_ena;
    logic              RF_W0;
    logic [ADDR_W-1:0] Rdc0;
    logic [DATA_W-1:0] Rd0;
    logic              RF_W1;
    logic [ADDR_W-1:0] Rdc1;
    logic [DATA_W-1:0] Rd1;
    logic [ADDR_W-1:0] Rsc;
    logic [ADDR_W-1:0] Rtc;
    logic [DATA_W-1:0] Rs;
    logic [DATA_W-1:0] Rt;
    logic              RF_clr;
    logic              RF_busy;

    modport master (
        output RF_ena, RF_W0, Rdc0, Rd0, RF_W1, Rdc1, Rd1, Rsc, Rtc, RF_clr,
        input  Rs, Rt, RF_busy
    );

    modport slave (
        input  RF_ena, RF_W0, Rdc0, Rd0, RF_W1, Rdc1, Rd1, Rsc, Rtc, RF_clr,
        output Rs, Rt, RF_busy
    );
endinterface

// File: rtl/rf_multiport.sv
// rf_multiport: 2-read / 2-write register file with a sequential soft-clear
// engine. Write port 1 has priority over port 0 on an address collision.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to
// the read ports (port 1 data wins when both ports hit the read address).
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          RF_clk,
    input  logic          RF_rst,
    rf_multiport_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_we0;
    logic              w_we1;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rs;
    logic [DATA_W-1:0] w_rt;

    // Register 0 is a constant zero when ZERO_REG is set.
    function automatic logic f_is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writes are only accepted in IDLE; writes during a clear are silently dropped.
    assign w_we0   = bus.RF_ena && bus.RF_W0 && (r_state == IDLE) && !f_is_zero(bus.Rdc0);
    assign w_we1   = bus.RF_ena && bus.RF_W1 && (r_state == IDLE) && !f_is_zero(bus.Rdc1);
    assign w_rd_en = bus.RF_ena && (r_state == IDLE);

    // State and clear-counter registers.
    always_ff @(posedge RF_clk) begin
        if (RF_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: a clear walks every address once; RF_ena low pauses it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.RF_ena && bus.RF_clr) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (bus.RF_ena) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == {ADDR_W{1'b1}}) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Register array: reset, one clear step per enabled cycle, or port writes
    // (port 1 assigned last so it overrides port 0 on the same address).
    always_ff @(posedge RF_clk) begin
        if (RF_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == CLEAR) begin
            if (bus.RF_ena) begin
                r_regs[r_cnt] <= '0;
            end
        end else begin
            if (w_we0) begin
                r_regs[bus.Rdc0] <= bus.Rd0;
            end
            if (w_we1) begin
                r_regs[bus.Rdc1] <= bus.Rd1;
            end
        end
    end

    // Combinational read ports, forced to zero when disabled, busy, or reading r0.
    always_comb begin
        w_rs = '0;
        w_rt = '0;
        if (w_rd_en && !f_is_zero(bus.Rsc)) begin
`ifdef RF_BYPASS_EN
            if (w_we1 && (bus.Rdc1 == bus.Rsc))
                w_rs = bus.Rd1;
            else if (w_we0 && (bus.Rdc0 == bus.Rsc))
                w_rs = bus.Rd0;
            else
`endif
                w_rs = r_regs[bus.Rsc];
        end
        if (w_rd_en && !f_is_zero(bus.Rtc)) begin
`ifdef RF_BYPASS_EN
            if (w_we1 && (bus.Rdc1 == bus.Rtc))
                w_rt = bus.Rd1;
            else if (w_we0 && (bus.Rdc0 == bus.Rtc))
                w_rt = bus.Rd0;
            else
`endif
                w_rt = r_regs[bus.Rtc];
        end
    end

    assign bus.Rs      = w_rs;
    assign bus.Rt      = w_rt;
    assign bus.RF_busy = (r_state == CLEAR);

endmodule
